uart_pulse_cmd: RTL
===================

UART_PULSE_CMD -- requirements
Module: uart_pulse_cmd

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, sys_clk frequency in Hz.
REQ-002 Parameter UART_BPS, default 9600, serial baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS (5208 at defaults).
REQ-003 Parameter TIMEOUT_CLKS, default 260_000, maximum idle gap between bytes of one frame, in sys_clk cycles.
REQ-004 sys_clk  input  1  system clock, all logic on rising edge.
REQ-005 sys_rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  UART serial line, 8N1, LSB first, idle high, asynchronous to sys_clk.
REQ-007 pulse_trig  output  1  one-cycle strobe requesting one pulse from the downstream pulse generator (its uart_flag input).
REQ-008 pulse_width  output  16  last accepted pulse width, held until the next accepted load command.
REQ-009 cmd  output  8  command byte of the last accepted frame.
REQ-010 frame_err  output  1  one-cycle strobe on any rejected byte or frame.

Function
REQ-011 rx SHALL pass through a 2-FF synchronizer; a third register SHALL provide falling-edge detection.
REQ-012 In RX idle, a synchronized falling edge SHALL start a byte; the baud counter SHALL count 0..BAUD_CNT_MAX-1 and wrap to 0.
REQ-013 Each bit SHALL be sampled when the baud counter equals BAUD_CNT_MAX/2.
REQ-014 A start bit sampled high SHALL be treated as a glitch: RX returns to idle, no byte, no frame_err.
REQ-015 Eight data bits SHALL be shifted in LSB first, then the stop bit sampled.
REQ-016 Stop bit high: internal byte_valid SHALL pulse one cycle, the cycle after the stop-bit sample.
REQ-017 Stop bit low: byte discarded, frame_err pulses one cycle, parser returns to IDLE.
REQ-018 Parser FSM states: IDLE, CMD, D_HI, D_LO, CHK; each transition occurs only on byte_valid, except timeout and reset.
REQ-019 IDLE: byte 0xAA -> CMD; any other byte silently ignored, stay IDLE.
REQ-020 CMD -> D_HI storing cmd byte; D_HI -> D_LO storing data[15:8]; D_LO -> CHK storing data[7:0]; 0xAA inside a frame is ordinary data.
REQ-021 CHK: on the checksum byte, compare against cmd ^ data[15:8] ^ data[7:0], then return to IDLE.
REQ-022 Checksum match, cmd 0x01 (load): pulse_width <= data, cmd <= 0x01, no trigger.
REQ-023 Checksum match, cmd 0x02 (fire): cmd <= 0x02, pulse_trig high one cycle, pulse_width unchanged, data ignored.
REQ-024 Checksum mismatch, or match with any other cmd value: frame_err one cycle, pulse_width and cmd unchanged, no trigger.
REQ-025 Outputs for an accepted or rejected frame SHALL update in the cycle after byte_valid of the checksum byte.
REQ-026 An idle counter SHALL clear on every byte_valid and count while the parser is not IDLE.
REQ-027 Idle counter reaching TIMEOUT_CLKS: parser -> IDLE, frame_err pulses one cycle, partial frame discarded; an RX byte in progress is unaffected.
REQ-028 A new frame SHALL be accepted in the byte time directly after the checksum byte (back-to-back frames).
REQ-029 pulse_trig and frame_err SHALL never be high in the same cycle.

Reset
REQ-030 Reset SHALL drive pulse_trig=0, frame_err=0, pulse_width=16'd0, cmd=8'd0.
REQ-031 Reset SHALL put RX in idle and the parser in IDLE, and clear all counters, shift register and synchronizer (synchronizer to 1).
REQ-032 Reset asserted mid-byte or mid-frame SHALL discard the partial data; after release, the next 0xAA starts a fresh frame.

Verification (bench overrides CLK_FREQ=1_600, UART_BPS=100 -> BAUD_CNT_MAX=16; TIMEOUT_CLKS=2_000)
REQ-033 Frame AA 01 00 32 33 -> pulse_width=16'h0032, cmd=8'h01, no pulse_trig, no frame_err.
REQ-034 Frame AA 02 00 00 02 -> exactly one pulse_trig cycle, pulse_width stays 16'h0032.
REQ-035 Frame AA 01 12 34 00 (bad checksum) -> one frame_err cycle, pulse_width and cmd unchanged.
REQ-036 Send AA 01 only, then idle 2_000 cycles -> one frame_err; then AA 02 00 00 02 -> one pulse_trig.
REQ-037 Byte with stop bit forced 0 mid-frame -> frame_err, parser IDLE; a 1-cycle low glitch on idle rx -> no byte, no frame_err.
REQ-038 sys_rst_n low during the D_LO byte -> all outputs 0; after release, AA 01 00 05 04 -> pulse_width=16'h0005.

Source files
------------

// File: rtl/uart_pulse_cmd.sv
// uart_pulse_cmd
//   Receives 8N1 UART bytes on rx. It parses 5-byte command frames of the form
//   AA <cmd> <data_hi> <data_lo> <chk>, where chk = cmd ^ data_hi ^ data_lo.
//   - cmd 0x01 (load): pulse_width <= data.
//   - cmd 0x02 (fire): pulse_trig strobes for one cycle.
//   - Bad checksum, unknown cmd, a stop-bit error or an inter-byte timeout:
//     frame_err strobes for one cycle.
//
// Ports
//   sys_clk          : system clock; all logic runs on the rising edge.
//   sys_rst_n        : asynchronous, active-low reset.
//   rx               : UART serial line. It idles high and is asynchronous to sys_clk.
//   pulse_trig       : one-cycle request to the downstream pulse generator.
//   pulse_width[15:0]: last accepted pulse width.
//   cmd[7:0]         : command byte of the last accepted frame.
//   frame_err        : one-cycle strobe on any rejected byte or frame.
//   rx_state_dbg     : current byte-receiver state.
//   parser_state_dbg : current frame-parser state.
//
// Handshake: the receiver hands each good byte to the parser as a single-cycle
// byte_valid pulse, with rx_byte stable. The parser has no back-pressure, so it
// must consume the byte in that cycle.
module uart_pulse_cmd #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 9600,
  parameter int TIMEOUT_CLKS = 260_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx,
  output logic        pulse_trig,
  output logic [15:0] pulse_width,
  output logic [7:0]  cmd,
  output logic        frame_err,
  output logic [1:0]  rx_state_dbg,
  output logic [2:0]  parser_state_dbg
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BAUD_HALF    = BAUD_CNT_MAX / 2;
  localparam int BW           = $clog2(BAUD_CNT_MAX);
  localparam int TW           = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_CMD, P_D_HI, P_D_LO, P_CHK} p_state_t;

  // ---------------- synchronizer and edge detect ----------------
  logic rx_s1, rx_s2, rx_s3;
  logic rx_fall;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;

  // ---------------- byte receiver ----------------
  rx_state_t       rx_state, rx_next;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            byte_valid;
  logic            rx_err;
  logic            mid;

  assign mid = (baud_cnt == BW'(BAUD_HALF));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) rx_state <= RX_IDLE;
    else            rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      // A start bit that reads high at mid-bit is a glitch, not a byte.
      RX_START: if (mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (mid && bit_cnt == 3'd7) rx_next = RX_STOP;
      // The receiver returns to idle at mid-stop. That leaves half a bit to
      // catch the start edge of a back-to-back byte.
      RX_STOP:  if (mid) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      if (rx_state == RX_IDLE || baud_cnt == BW'(BAUD_CNT_MAX - 1))
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;

      if (rx_state == RX_START)
        bit_cnt <= '0;
      else if (rx_state == RX_DATA && mid)
        bit_cnt <= bit_cnt + 1'b1;

      if (rx_state == RX_DATA && mid)
        rx_byte <= {rx_s2, rx_byte[7:1]};

      byte_valid <= (rx_state == RX_STOP) && mid &&  rx_s2;
      rx_err     <= (rx_state == RX_STOP) && mid && !rx_s2;
    end
  end

  // ---------------- frame parser ----------------
  p_state_t      p_state, p_next;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    cmd_byte, d_hi, d_lo;
  logic          timeout;
  logic          accept_load, accept_fire, reject;

  // A byte arriving in the same cycle as the timeout takes precedence, so the
  // frame is not dropped on that exact cycle.
  assign timeout = (p_state != P_IDLE) && (idle_cnt == TW'(TIMEOUT_CLKS)) && !byte_valid;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) p_state <= P_IDLE;
    else            p_state <= p_next;
  end

  always_comb begin
    p_next      = p_state;
    accept_load = 1'b0;
    accept_fire = 1'b0;
    reject      = 1'b0;
    if (byte_valid) begin
      case (p_state)
        P_IDLE: if (rx_byte == 8'hAA) p_next = P_CMD;
        P_CMD:  p_next = P_D_HI;
        P_D_HI: p_next = P_D_LO;
        P_D_LO: p_next = P_CHK;
        P_CHK: begin
          p_next = P_IDLE;
          if (rx_byte == (cmd_byte ^ d_hi ^ d_lo)) begin
            if      (cmd_byte == 8'h01) accept_load = 1'b1;
            else if (cmd_byte == 8'h02) accept_fire = 1'b1;
            else                        reject      = 1'b1;
          end else begin
            reject = 1'b1;
          end
        end
        default: p_next = P_IDLE;
      endcase
    end else if (rx_err || timeout) begin
      p_next = P_IDLE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idle_cnt    <= '0;
      cmd_byte    <= '0;
      d_hi        <= '0;
      d_lo        <= '0;
      pulse_width <= '0;
      cmd         <= '0;
      pulse_trig  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      if (byte_valid || p_state == P_IDLE || timeout)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      if (byte_valid) begin
        if (p_state == P_CMD)  cmd_byte <= rx_byte;
        if (p_state == P_D_HI) d_hi     <= rx_byte;
        if (p_state == P_D_LO) d_lo     <= rx_byte;
      end

      if (accept_load) begin
        pulse_width <= {d_hi, d_lo};
        cmd         <= 8'h01;
      end
      if (accept_fire)
        cmd <= 8'h02;

      // Trigger only on an accepted fire. Errors only on a reject, a framing
      // error or a timeout. These sources are mutually exclusive.
      pulse_trig <= accept_fire;
      frame_err  <= reject | rx_err | timeout;
    end
  end

  assign rx_state_dbg     = rx_state;
  assign parser_state_dbg = p_state;

endmodule
